// File: rtl/ask4_symbol_source.sv
// 4-ASK test-symbol source: single impulse or PRBS-driven Gray-mapped 4-ASK stream,
// upsampled to the sample rate by zero-stuffing or holding.
module ask4_symbol_source #(
    parameter int                        WIDTH     = 18,
    parameter logic signed [WIDTH-1:0]   LVL_OUT   = 18'sd98303,
    parameter logic signed [WIDTH-1:0]   LVL_IN    = 18'sd32768,
    parameter logic signed [WIDTH-1:0]   IMP_AMP   = 18'sd131071,
    parameter int                        IMP_LEN   = 128,
    parameter int                        NSYM      = 0,
    parameter bit                        ZSTUFF    = 1'b1,
    parameter logic [21:0]               LFSR_SEED = 22'h3FFFFF
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     sam_clk_en,
    input  logic                     sym_clk_en,
    input  logic                     start,
    input  logic                     mode,
    input  logic                     stop,
    output logic signed [WIDTH-1:0]  x_out,
    output logic [1:0]               sym_out,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              sym_cnt
);

    localparam int          IMPW      = $clog2(IMP_LEN + 1);
    localparam bit          HAS_NSYM  = (NSYM > 0);
    localparam logic [15:0] NSYM_W    = 16'(NSYM);
    localparam logic [IMPW-1:0] IMP_LAST = IMPW'(IMP_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_IMP,
        S_PRBS
    } state_t;

    state_t                  r_state,    w_stateNext;
    logic                    r_mode,     w_modeNext;
    logic [21:0]             r_lfsr,     w_lfsrNext;
    logic signed [WIDTH-1:0] r_x,        w_xNext;
    logic [1:0]              r_sym,      w_symNext;
    logic                    r_busy,     w_busyNext;
    logic                    r_done,     w_doneNext;
    logic [15:0]             r_symCnt,   w_symCntNext;
    logic [IMPW-1:0]         r_impCnt,   w_impCntNext;
    logic                    r_stopPend, w_stopPendNext;
    logic                    w_symTick;
    logic                    w_symLimit;

    function automatic logic signed [WIDTH-1:0] grayMap(input logic [1:0] s);
        case (s)
            2'b00:   return -LVL_OUT;
            2'b01:   return -LVL_IN;
            2'b11:   return LVL_IN;
            default: return LVL_OUT;
        endcase
    endfunction

    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_x        <= '0;
            r_sym      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_symCnt   <= '0;
            r_impCnt   <= '0;
            r_stopPend <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_mode     <= w_modeNext;
            r_lfsr     <= w_lfsrNext;
            r_x        <= w_xNext;
            r_sym      <= w_symNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_symCnt   <= w_symCntNext;
            r_impCnt   <= w_impCntNext;
            r_stopPend <= w_stopPendNext;
        end
    end

    // A stop seen between sample strobes is remembered until the next sam_clk_en acts on it.
    always_comb begin
        w_stateNext    = r_state;
        w_modeNext     = r_mode;
        w_lfsrNext     = r_lfsr;
        w_xNext        = r_x;
        w_symNext      = r_sym;
        w_doneNext     = 1'b0;
        w_symCntNext   = r_symCnt;
        w_impCntNext   = r_impCnt;
        w_stopPendNext = r_stopPend;
        w_symTick      = sam_clk_en && sym_clk_en;
        w_symLimit     = HAS_NSYM && (r_symCnt == NSYM_W);

        if (r_state == S_IDLE) begin
            w_xNext        = '0;
            w_stopPendNext = 1'b0;
            if (start) begin
                w_modeNext   = mode;
                w_lfsrNext   = LFSR_SEED;
                w_symCntNext = '0;
                w_impCntNext = '0;
                w_stateNext  = S_ARM;
            end
        end else begin
            if (stop) begin
                w_stopPendNext = 1'b1;
            end
            if ((stop || r_stopPend) && sam_clk_en) begin
                w_xNext        = '0;
                w_stopPendNext = 1'b0;
                w_stateNext    = S_IDLE;
            end else begin
                case (r_state)
                    S_ARM: begin
                        if (w_symTick) begin
                            if (!r_mode) begin
                                w_xNext      = IMP_AMP;
                                w_impCntNext = '0;
                                w_stateNext  = S_IMP;
                            end else begin
                                w_symNext    = r_lfsr[1:0];
                                w_xNext      = grayMap(r_lfsr[1:0]);
                                w_symCntNext = r_symCnt + 16'd1;
                                w_lfsrNext   = {r_lfsr[20:0], r_lfsr[21] ^ r_lfsr[20]};
                                w_stateNext  = S_PRBS;
                            end
                        end
                    end
                    S_IMP: begin
                        if (sam_clk_en) begin
                            w_xNext      = '0;
                            w_impCntNext = r_impCnt + 1'b1;
                            if (r_impCnt == IMP_LAST) begin
                                w_doneNext  = 1'b1;
                                w_stateNext = S_IDLE;
                            end
                        end
                    end
                    S_PRBS: begin
                        if (w_symTick) begin
                            if (w_symLimit) begin
                                w_xNext     = '0;
                                w_doneNext  = 1'b1;
                                w_stateNext = S_IDLE;
                            end else begin
                                w_symNext    = r_lfsr[1:0];
                                w_xNext      = grayMap(r_lfsr[1:0]);
                                w_symCntNext = r_symCnt + 16'd1;
                                w_lfsrNext   = {r_lfsr[20:0], r_lfsr[21] ^ r_lfsr[20]};
                            end
                        end else if (sam_clk_en && ZSTUFF) begin
                            w_xNext = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end

        w_busyNext = (w_stateNext != S_IDLE);
    end

    assign x_out   = r_x;
    assign sym_out = r_sym;
    assign busy    = r_busy;
    assign done    = r_done;
    assign sym_cnt = r_symCnt;

endmodule

// File: tb/tb_ask4_symbol_source.sv
// Directed bench: instance A stops after 4 symbols with zero-stuffing,
// instance B free-runs and holds symbols; both share stimulus and strobes.
module tb_ask4_symbol_source;

    logic               sys_clk;
    logic               reset;
    logic               sam_clk_en;
    logic               sym_clk_en;
    logic               start;
    logic               mode;
    logic               stop;
    logic signed [17:0] xA, xB;
    logic [1:0]         symA, symB;
    logic               busyA, busyB;
    logic               doneA, doneB;
    logic [15:0]        cntA, cntB;

    int total = 0;
    int bad   = 0;
    logic lastSym;

    ask4_symbol_source #(.NSYM(4), .ZSTUFF(1'b1)) uA (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .start(start), .mode(mode), .stop(stop),
        .x_out(xA), .sym_out(symA), .busy(busyA), .done(doneA), .sym_cnt(cntA)
    );

    ask4_symbol_source #(.NSYM(0), .ZSTUFF(1'b0)) uB (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .start(start), .mode(mode), .stop(stop),
        .x_out(xB), .sym_out(symB), .busy(busyB), .done(doneB), .sym_cnt(cntB)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Sample strobe every 2nd clock, symbol strobe on every 4th sample strobe.
    initial begin
        int phase;
        phase      = 0;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        forever begin
            @(negedge sys_clk);
            phase      = (phase + 1) % 8;
            sam_clk_en = (phase % 2 == 0);
            sym_clk_en = (phase == 0);
        end
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic md, input logic sp);
        start = st;
        mode  = md;
        stop  = sp;
    endtask

    task automatic nextSam;
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        do begin
            @(posedge sys_clk);
            n++;
            hit     = sam_clk_en;
            lastSym = sym_clk_en;
        end while (!hit && n < 20);
        #1;
        checkOutput("samTimeout", 32'(hit), 1);
    endtask

    task automatic nextSym;
        int n;
        n = 0;
        do begin
            nextSam();
            n++;
        end while (!lastSym && n < 10);
        checkOutput("symTimeout", 32'(lastSym), 1);
    endtask

    task automatic startRun(input logic md, input logic withStop);
        applyStimulus(1'b1, md, withStop);
        @(posedge sys_clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int expSym[4];
        int expGray[4];
        expSym  = '{32768, 98303, -98303, -98303};
        expGray = '{3, 2, 0, 0};
        lastSym = 1'b0;

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge sys_clk);
        #1;
        checkOutput("rstX", xA, 0);
        checkOutput("rstSym", symA, 0);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstDone", doneA, 0);
        checkOutput("rstCnt", cntA, 0);
        checkOutput("rstXB", xB, 0);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;

        // Impulse run
        startRun(1'b0, 1'b0);
        checkOutput("impArmBusy", busyA, 1);
        checkOutput("impArmX", xA, 0);
        nextSym();
        checkOutput("impPeak", xA, 131071);
        checkOutput("impPeakB", xB, 131071);
        checkOutput("impPeakDone", doneA, 0);
        for (int i = 1; i <= 128; i++) begin
            nextSam();
            checkOutput("impZero", xA, 0);
            checkOutput("impDone", doneA, (i == 128) ? 1 : 0);
            checkOutput("impBusy", busyA, (i == 128) ? 0 : 1);
        end
        @(posedge sys_clk);
        #1;
        checkOutput("impDonePulse", doneA, 0);

        // PRBS run, started with start and stop together
        startRun(1'b1, 1'b1);
        checkOutput("prbsArmBusyA", busyA, 1);
        checkOutput("prbsArmBusyB", busyB, 1);
        for (int k = 0; k < 4; k++) begin
            nextSym();
            checkOutput("symX", xA, expSym[k]);
            checkOutput("symGray", symA, expGray[k]);
            checkOutput("symCnt", cntA, k + 1);
            checkOutput("symXB", xB, expSym[k]);
            for (int j = 1; j < 4; j++) begin
                nextSam();
                checkOutput("zstuffX", xA, 0);
                checkOutput("holdXB", xB, expSym[k]);
            end
        end
        nextSym();
        checkOutput("termX", xA, 0);
        checkOutput("termDone", doneA, 1);
        checkOutput("termBusy", busyA, 0);
        checkOutput("termCnt", cntA, 4);
        checkOutput("sym5XB", xB, -98303);
        checkOutput("sym5CntB", cntB, 5);
        checkOutput("sym5DoneB", doneB, 0);
        @(posedge sys_clk);
        #1;
        checkOutput("termDonePulse", doneA, 0);

        // Free run to 10 symbols, then stop (stray stop for idle instance A)
        for (int k = 6; k <= 10; k++) begin
            nextSym();
            checkOutput("runCntB", cntB, k);
            checkOutput("runBusyB", busyB, 1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        nextSam();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stopX", xB, 0);
        checkOutput("stopBusy", busyB, 0);
        checkOutput("stopDone", doneB, 0);
        checkOutput("strayStopBusyA", busyA, 0);
        checkOutput("strayStopXA", xA, 0);
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("stopNoDone", doneB, 0);
        checkOutput("stopIdle", busyB, 0);

        // Start pulse while busy must not alter the run
        startRun(1'b1, 1'b0);
        nextSym();
        checkOutput("ignX1", xA, 32768);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge sys_clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        nextSym();
        checkOutput("ignX2", xA, 98303);
        checkOutput("ignGray2", symA, 2);
        checkOutput("ignCnt2", cntA, 2);
        checkOutput("ignBusy", busyA, 1);

        // Reset mid-run, then restart
        reset = 1'b0;
        @(posedge sys_clk);
        #1;
        checkOutput("midRstX", xA, 0);
        checkOutput("midRstSym", symA, 0);
        checkOutput("midRstBusy", busyA, 0);
        checkOutput("midRstDone", doneA, 0);
        checkOutput("midRstCnt", cntA, 0);
        checkOutput("midRstXB", xB, 0);
        checkOutput("midRstBusyB", busyB, 0);
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        startRun(1'b1, 1'b0);
        nextSym();
        checkOutput("reX1", xA, 32768);
        checkOutput("reX1B", xB, 32768);
        nextSym();
        checkOutput("reX2", xA, 98303);
        checkOutput("reX2B", xB, 98303);
        applyStimulus(1'b0, 1'b1, 1'b1);
        nextSam();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("endBusyA", busyA, 0);
        checkOutput("endBusyB", busyB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
